// File: rtl/lcd_nibble_driver_pkg.sv
// Shared types and constants for the HD44780 4-bit nibble driver.
// Imported by the driver top; timing defaults live on the module.
package lcd_nibble_driver_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_drv_state_e;

    localparam logic [3:0] LCD_CMD_CLEAR_LO = 4'b0001;
    localparam logic [3:0] LCD_CMD_HOME_LO  = 4'b0010;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Low half of clear (0x01) or home (0x02/0x03).
    function automatic logic is_slow_lo(input logic [3:0] d);
        return (d == LCD_CMD_CLEAR_LO) ||
               (d == LCD_CMD_HOME_LO) ||
               (d == (LCD_CMD_CLEAR_LO | LCD_CMD_HOME_LO));
    endfunction

endpackage

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit physical driver: power-up delay, RS/D setup,
// E strobe, hold and execution wait behind a valid/ready port.
module lcd_nibble_driver
    import lcd_nibble_driver_pkg::*;
#(
    parameter int CLK_HZ      = 27_000_000,
    parameter int POWERUP_CYC = 1_080_000,
    parameter int SETUP_CYC   = 2,
    parameter int E_HIGH_CYC  = 8,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 1_080,
    parameter int LONG_CYC    = 41_310
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_display_data,
    input  logic       i_display_data_valid,
    input  logic       i_RS,
    output logic       o_is_ready,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [3:0] o_lcd_d
);

    localparam int MAXP = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                    max2(E_HIGH_CYC, HOLD_CYC)),
                               max2(EXEC_CYC, LONG_CYC));
    localparam int CW = $clog2(MAXP) + 1;

    if (CLK_HZ < 1) begin : g_clk_hz_unset
    end

    lcd_drv_state_e state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           ready_n, e_n, rs_n, prev_rs, prev_rs_n;
    logic [3:0]     d_n, prev_d, prev_d_n;
    logic           cnt_zero, accept, long_wait;

    assign o_lcd_rw  = 1'b0;
    assign cnt_zero  = (cnt == '0);
    assign accept    = o_is_ready && i_display_data_valid;
    assign long_wait = !o_lcd_rs && is_slow_lo(o_lcd_d) &&
                       !prev_rs && (prev_d == 4'b0000);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= POWERUP;
            cnt        <= CW'(POWERUP_CYC - 1);
            o_is_ready <= 1'b0;
            o_lcd_e    <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_d    <= 4'h0;
            prev_d     <= 4'hF;
            prev_rs    <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            o_is_ready <= ready_n;
            o_lcd_e    <= e_n;
            o_lcd_rs   <= rs_n;
            o_lcd_d    <= d_n;
            prev_d     <= prev_d_n;
            prev_rs    <= prev_rs_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_zero ? cnt : cnt - 1'b1;
        unique case (1'b1)
            (state == POWERUP): begin
                if (cnt_zero) state_n = IDLE;
            end
            (state == IDLE): begin
                if (accept) begin
                    state_n = SETUP;
                    cnt_n   = CW'(SETUP_CYC - 1);
                end
            end
            (state == SETUP): begin
                if (cnt_zero) begin
                    state_n = PULSE;
                    cnt_n   = CW'(E_HIGH_CYC - 1);
                end
            end
            (state == PULSE): begin
                if (cnt_zero) begin
                    state_n = HOLD;
                    cnt_n   = CW'(HOLD_CYC - 1);
                end
            end
            (state == HOLD): begin
                if (cnt_zero) begin
                    state_n = WAIT;
                    cnt_n   = long_wait ? CW'(LONG_CYC - 1)
                                        : CW'(EXEC_CYC - 1);
                end
            end
            (state == WAIT): begin
                if (cnt_zero) state_n = IDLE;
            end
            default: state_n = POWERUP;
        endcase
    end

    always_comb begin
        ready_n   = o_is_ready;
        e_n       = o_lcd_e;
        rs_n      = o_lcd_rs;
        d_n       = o_lcd_d;
        prev_d_n  = prev_d;
        prev_rs_n = prev_rs;
        unique case (1'b1)
            (state == POWERUP): begin
                if (cnt_zero) ready_n = 1'b1;
            end
            (state == IDLE): begin
                if (accept) begin
                    d_n     = i_display_data;
                    rs_n    = i_RS;
                    ready_n = 1'b0;
                end
            end
            (state == SETUP): begin
                if (cnt_zero) e_n = 1'b1;
            end
            (state == PULSE): begin
                if (cnt_zero) e_n = 1'b0;
            end
            (state == HOLD): begin
                if (cnt_zero) begin
                    prev_d_n  = o_lcd_d;
                    prev_rs_n = o_lcd_rs;
                end
            end
            (state == WAIT): begin
                if (cnt_zero) ready_n = 1'b1;
            end
            default: ready_n = 1'b0;
        endcase
    end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Physical-side driver for the HD44780-compatible character LCD in 4-bit mode. It accepts one nibble plus RS per handshake from the display controller, then drives RS, D[7:4] and the E strobe with the required setup, pulse-width and hold times. It waits out the LCD execution time before accepting the next nibble. It also enforces the LCD power-up delay after reset and is the responder for the controller's valid/ready nibble interface.

## Interface
- CLK_HZ, 27_000_000, system clock frequency; documentation only, all timing is given in cycles
- POWERUP_CYC, 1_080_000, cycles after reset before the first nibble is accepted (40 ms)
- SETUP_CYC, 2, cycles RS/D are stable before E rises (≥40 ns)
- E_HIGH_CYC, 8, cycles E is high (≥230 ns)
- HOLD_CYC, 2, cycles RS/D are held after E falls (≥10 ns)
- EXEC_CYC, 1_080, post-nibble wait for normal nibbles (40 µs)
- LONG_CYC, 41_310, post-nibble wait for clear/home (1.53 ms)
- All parameters must be ≥1

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_display_data  in  4  nibble to send
- i_display_data_valid  in  1  nibble offered
- i_RS  in  1  register select for this nibble (0 = command, 1 = data)
- o_is_ready  out  1  driver can accept a nibble this cycle
- o_lcd_e  out  1  LCD enable strobe
- o_lcd_rs  out  1  LCD RS pin
- o_lcd_rw  out  1  LCD R/W pin, constant 0 (write only)
- o_lcd_d  out  4  LCD D[7:4]

## Operation
- State machine states: POWERUP, IDLE, SETUP, PULSE, HOLD, WAIT.
- A single down-counter serves all states. It is sized `$clog2` of the largest parameter plus 1.
- Reset values:
  - state POWERUP, counter = POWERUP_CYC-1
  - o_is_ready 0, o_lcd_e 0, o_lcd_rs 0, o_lcd_d 0
  - previous-nibble register = 4'hF, previous-RS = 1
- POWERUP: count down; at 0 go to IDLE and set o_is_ready=1.
- IDLE: a transfer occurs when o_is_ready && i_display_data_valid in the same cycle.
  - On that edge: capture data into o_lcd_d and RS into o_lcd_rs, clear o_is_ready, load counter SETUP_CYC-1, go to SETUP.
  - Valid while not ready is ignored; no capture.
- SETUP: at 0, set o_lcd_e=1, load E_HIGH_CYC-1, go to PULSE.
- PULSE: at 0, set o_lcd_e=0, load HOLD_CYC-1, go to HOLD.
- HOLD: at 0, load the wait count, go to WAIT. o_lcd_rs/o_lcd_d are unchanged through HOLD and WAIT.
- Wait count selection:
  - LONG_CYC-1 when the current nibble has RS=0, value 4'b0001/4'b0010/4'b0011, and the previous accepted nibble had RS=0 and value 4'b0000. This is the low half of clear (0x01) or home (0x02/0x03).
  - Otherwise EXEC_CYC-1.
  - False positives (e.g. a 0x?0 command followed by a 0x1?/0x2?/0x3? command's high nibble) only lengthen the wait, which is acceptable.
- The previous-nibble register updates at HOLD exit with the current nibble and RS.
- WAIT: at 0, set o_is_ready=1, go to IDLE.
- Reset mid-operation: E drops to 0 asynchronously, the in-flight nibble is discarded, and the full POWERUP delay restarts.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- With the accept edge at cycle k:
  - RS/D are valid from k+1.
  - E is high during cycles k+1+S … k+S+E.
  - o_is_ready returns high at cycle k+1+S+E+H+W.
  - S = SETUP_CYC, E = E_HIGH_CYC, H = HOLD_CYC, W = chosen wait.
- Nibble throughput is one per S+E+H+W+1 cycles.
- First o_is_ready=1 occurs POWERUP_CYC cycles after reset deassertion.
- The display controller may present valid combinationally from o_is_ready. This is legal because o_is_ready is registered.

## Structure
- common_pkg additions:
  - typedef enum lcd_drv_state_e {POWERUP, IDLE, SETUP, PULSE, HOLD, WAIT}
  - localparams LCD_CMD_CLEAR_LO = 4'b0001, LCD_CMD_HOME_LO = 4'b0010
- Default timing values are module parameters, not package constants.
- No sub-module: one FSM and one down-counter in a single always_ff, with a small comb next-state block.

## Test plan
Sim parameters: POWERUP=10, SETUP=2, E_HIGH=3, HOLD=1, EXEC=5, LONG=20.

- Reset release with valid held high → o_is_ready stays 0 for 10 cycles, then first accept; no E pulse before then.
- Send nibble 4'b0010, RS=0 → D=0010, RS=0 for 2 cycles before E; E high exactly 3 cycles; D held 1 cycle after; o_is_ready high 12 cycles after the accept edge (1+2+3+1+5).
- Send 0000 then 0001, both RS=0 → the second nibble's ready-return uses the 20-cycle wait (27 cycles after accept). Repeat with RS=1 on either nibble → 5-cycle wait.
- Toggle valid while busy with changing data → no capture; o_lcd_d is unchanged until the next ready cycle.
- Assert i_rst while E=1 → o_lcd_e=0 in the same cycle (async), o_is_ready=0, and a 10-cycle powerup restart.
- Stream the 9-nibble controller init sequence back-to-back → 9 E pulses with correct D/RS order, and no overlap of E with an RS/D change.
